pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 24 ++
 rtl/pc_fetch.sv | 174 +++++++++++++++++
 tb/tb_pc_fetch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared definitions for the instruction fetch stage.
// Holds the bus widths, reset/stall polarities, the address-error
// exception code and the fetch FSM state encoding.
package pc_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b1;
    localparam logic        Stop      = 1'b1;
    localparam logic        NotStop   = 1'b0;

    // Exception word reported for a misaligned instruction address (AdEL).
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;

    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_REQ   = 2'd1,
        FS_WAIT  = 2'd2,
        FS_HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage.
// Issues one read at a time to instruction memory, registers the returned
// instruction and its PC for the IF/ID register, and computes the next PC
// (flush target > branch target > pc+4).
//
// Handshake: inst_req/inst_addr stay asserted and stable from the REQ cycle
// until the cycle inst_rvalid is seen; that cycle delivers inst_rdata. A
// response belonging to a request killed by flush is discarded once (drop_q).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall[5:0]                stall vector, bit0 holds the fetch stage
//   flush, new_pc             exception flush and handler address
//   bflag, branch_address_i   taken branch from ID and its target
//   inst_rdata, inst_rvalid   instruction memory response
//   inst_req, inst_addr       instruction memory request
//   if_pc, if_inst            fetched PC / instruction to IF/ID
//   excepttype_o              fetch exception word to IF/ID
//   stallreq_if               fetch stall request
//   dbg_state_o               current FSM state (debug)
module pc_fetch
    import pc_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] new_pc,
    input  logic                   bflag,
    input  logic [InstAddrBus-1:0] branch_address_i,
    input  logic [InstBus-1:0]     inst_rdata,
    input  logic                   inst_rvalid,
    output logic                   inst_req,
    output logic [InstAddrBus-1:0] inst_addr,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic [31:0]            excepttype_o,
    output logic                   stallreq_if,
    output logic [1:0]             dbg_state_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] if_pc_q, if_pc_d;
    logic [InstBus-1:0]     if_inst_q, if_inst_d;
    logic [31:0]            exc_q, exc_d;
    logic                   br_pend_q, br_pend_d;
    logic [InstAddrBus-1:0] br_target_q, br_target_d;
    logic                   drop_q, drop_d;
    logic                   adel_q, adel_d;

    logic                   aligned;
    logic                   rvalid_ok;
    logic                   req_c;
    logic                   deliver;
    logic [InstAddrBus-1:0] next_pc;

    // Only the fetch-stage bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    always_comb begin
        aligned   = (pc_q[1:0] == 2'b00);
        // A response arriving while drop_q is set belongs to a killed request.
        rvalid_ok = inst_rvalid && !drop_q;
        req_c     = ((state_q == FS_REQ) && aligned) || (state_q == FS_WAIT);
        deliver   = req_c && rvalid_ok;
        // A branch latched earlier is older than one arriving now, so it wins.
        if (br_pend_q) begin
            next_pc = br_target_q;
        end else if (bflag) begin
            next_pc = branch_address_i;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        exc_d       = exc_q;
        br_pend_d   = br_pend_q;
        br_target_d = br_target_q;
        drop_d      = drop_q;
        adel_d      = adel_q;

        if (inst_rvalid && drop_q) begin
            drop_d = 1'b0;
        end

        if (flush) begin
            state_d   = FS_REQ;
            pc_d      = new_pc;
            if_pc_d   = ZeroWord;
            if_inst_d = ZeroWord;
            exc_d     = ZeroWord;
            br_pend_d = 1'b0;
            adel_d    = 1'b0;
            // Some request is still outstanding after this cycle unless the
            // only one in flight was answered right now.
            drop_d    = req_c && (drop_q || !inst_rvalid);
        end else begin
            case (state_q)
                FS_RESET: state_d = FS_REQ;
                FS_REQ: begin
                    if (!aligned) begin
                        // Misaligned PC: report AdEL and park until flushed.
                        if_pc_d   = pc_q;
                        if_inst_d = ZeroWord;
                        exc_d     = EXC_ADEL;
                        adel_d    = 1'b1;
                        state_d   = FS_HOLD;
                    end else if (!deliver) begin
                        state_d = FS_WAIT;
                    end
                end
                FS_WAIT: ;
                FS_HOLD: begin
                    if (!adel_q && (stall[0] == NotStop)) begin
                        state_d = FS_REQ;
                    end
                end
                default: state_d = FS_RESET;
            endcase

            if (deliver) begin
                if_pc_d   = pc_q;
                if_inst_d = inst_rdata;
                exc_d     = ZeroWord;
                pc_d      = next_pc;
                br_pend_d = 1'b0;
                state_d   = (stall[0] == Stop) ? FS_HOLD : FS_REQ;
            end else if (bflag && (state_q != FS_RESET)) begin
                br_pend_d   = 1'b1;
                br_target_d = branch_address_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= FS_RESET;
            pc_q        <= ZeroWord;
            if_pc_q     <= ZeroWord;
            if_inst_q   <= ZeroWord;
            exc_q       <= ZeroWord;
            br_pend_q   <= 1'b0;
            br_target_q <= ZeroWord;
            drop_q      <= 1'b0;
            adel_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            exc_q       <= exc_d;
            br_pend_q   <= br_pend_d;
            br_target_q <= br_target_d;
            drop_q      <= drop_d;
            adel_q      <= adel_d;
        end
    end

    assign inst_req     = req_c;
    assign inst_addr    = pc_q;
    assign stallreq_if  = req_c && !rvalid_ok;
    assign if_pc        = if_pc_q;
    assign if_inst      = if_inst_q;
    assign excepttype_o = exc_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bflag;
    logic [31:0] branch_address_i;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] excepttype_o;
    logic        stallreq_if;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .bflag            (bflag),
        .branch_address_i (branch_address_i),
        .inst_rdata       (inst_rdata),
        .inst_rvalid      (inst_rvalid),
        .inst_req         (inst_req),
        .inst_addr        (inst_addr),
        .if_pc            (if_pc),
        .if_inst          (if_inst),
        .excepttype_o     (excepttype_o),
        .stallreq_if      (stallreq_if),
        .dbg_state_o      (dbg_state)
    );

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        logic        rst;
        logic        stall0;
        logic        flush;
        logic [31:0] new_pc;
        logic        bflag;
        logic [31:0] br;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sreq;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_exc;
    } vec_t;

    vec_t        vecs[$];
    logic [95:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Instruction memory contents as seen by the bench.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic f, input logic [31:0] np,
                       input logic b, input logic [31:0] ba, input logic rv, input logic [31:0] rd,
                       input logic er, input logic [31:0] ea, input logic es,
                       input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] ee);
        vec_t v;
        v.rst = r; v.stall0 = s; v.flush = f; v.new_pc = np; v.bflag = b; v.br = ba;
        v.rv = rv; v.rdata = rd; v.e_req = er; v.e_addr = ea; v.e_sreq = es;
        v.e_pc = ep; v.e_inst = ei; v.e_exc = ee;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic apply(input vec_t v, input string tag);
        logic [95:0] e;
        @(negedge clk);
        rst              = v.rst;
        stall            = {5'b0, v.stall0};
        flush            = v.flush;
        new_pc           = v.new_pc;
        bflag            = v.bflag;
        branch_address_i = v.br;
        inst_rvalid      = v.rv;
        inst_rdata       = v.rdata;
        #1;
        check32({tag, " inst_req"},    {31'b0, inst_req},    {31'b0, v.e_req});
        check32({tag, " inst_addr"},   inst_addr,            v.e_addr);
        check32({tag, " stallreq_if"}, {31'b0, stallreq_if}, {31'b0, v.e_sreq});
        exp_q.push_back({v.e_pc, v.e_inst, v.e_exc});
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            n_checks--;
            e = exp_q.pop_front();
            check32({tag, " if_pc"},        if_pc,        e[95:64]);
            check32({tag, " if_inst"},      if_inst,      e[63:32]);
            check32({tag, " excepttype_o"}, excepttype_o, e[31:0]);
        end
    endtask

    // Sequential fetches with random memory latency, starting in REQ.
    task automatic random_run(input int count, input logic [31:0] start_pc,
                              input logic [31:0] last_pc, input logic [31:0] last_inst);
        logic [31:0] pc;
        logic [31:0] lp;
        logic [31:0] li;
        int          lat;
        vec_t        v;
        pc = start_pc; lp = last_pc; li = last_inst;
        for (int k = 0; k < count; k++) begin
            lat = $urandom_range(0, 3);
            for (int w = 0; w < lat; w++) begin
                v = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                      1'b1, pc, 1'b1, lp, li, 32'h0};
                apply(v, $sformatf("rnd%0d.w%0d", k, w));
            end
            v = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mw(pc),
                  1'b1, pc, 1'b0, pc, mw(pc), 32'h0};
            apply(v, $sformatf("rnd%0d.d", k));
            lp = pc; li = mw(pc);
            pc = pc + 32'd4;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; bflag = 1'b0;
        branch_address_i = '0; inst_rvalid = 1'b0; inst_rdata = '0;
        repeat (2) @(posedge clk);

        //  rst s  f  new_pc        b  br          rv rdata          req addr           sreq if_pc          if_inst         exc
        add(1, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(0),          0, 32'h0,          0, 32'h0,          32'h0,          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(0),          1, 32'h0,          0, 32'h0,          mw(0),          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(4),          1, 32'h4,          0, 32'h4,          mw(4),          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          1, 32'h8,          1, 32'h4,          mw(4),          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          1, 32'h8,          1, 32'h4,          mw(4),          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          1, 32'h8,          1, 32'h4,          mw(4),          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(8),          1, 32'h8,          0, 32'h8,          mw(8),          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(12),         1, 32'hC,          0, 32'hC,          mw(12),         32'h0);
        add(0, 1, 0, 32'h0,        0, 32'h0,     1, mw(16),         1, 32'h10,         0, 32'h10,         mw(16),         32'h0);
        add(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,          0, 32'h14,         0, 32'h10,         mw(16),         32'h0);
        add(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,          0, 32'h14,         0, 32'h10,         mw(16),         32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          0, 32'h14,         0, 32'h10,         mw(16),         32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(20),         1, 32'h14,         0, 32'h14,         mw(20),         32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          1, 32'h18,         1, 32'h14,         mw(20),         32'h0);
        add(0, 0, 0, 32'h0,        1, 32'h100,   0, 32'h0,          1, 32'h18,         1, 32'h14,         mw(20),         32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(24),         1, 32'h18,         0, 32'h18,         mw(24),         32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(32'h100),    1, 32'h100,        0, 32'h100,        mw(32'h100),    32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          1, 32'h104,        1, 32'h100,        mw(32'h100),    32'h0);
        add(0, 0, 1, 32'h180,      1, 32'h200,   0, 32'h0,          1, 32'h104,        1, 32'h0,          32'h0,          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, 32'hDEADBEEF,   1, 32'h180,        1, 32'h0,          32'h0,          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(32'h180),    1, 32'h180,        0, 32'h180,        mw(32'h180),    32'h0);
        add(0, 0, 0, 32'h0,        1, 32'h102,   0, 32'h0,          1, 32'h184,        1, 32'h180,        mw(32'h180),    32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(32'h184),    1, 32'h184,        0, 32'h184,        mw(32'h184),    32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          0, 32'h102,        0, 32'h102,        32'h0,          32'h4);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          0, 32'h102,        0, 32'h102,        32'h0,          32'h4);
        add(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,     0, 32'h0,          0, 32'h102,        0, 32'h0,          32'h0,          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(32'hFFFFFFFC), 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC,   mw(32'hFFFFFFFC), 32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(0),          1, 32'h0,          0, 32'h0,          mw(0),          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          1, 32'h4,          1, 32'h0,          mw(0),          32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h0,          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, 32'hDEADBEEF,   0, 32'h0,          0, 32'h0,          32'h0,          32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,     1, mw(0),          1, 32'h0,          0, 32'h0,          mw(0),          32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        random_run(20, 32'h4, 32'h0, mw(0));

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
